data_mem_responder: RTL

//   Word-addressed data memory on the responder side of the CPU load/store port of the pipelined MIPS.
//   MEM stage issues one request (lw/sw) per handshake; block services it after a fixed latency and

---
 rtl/mem_pkg.sv | 6 +
 rtl/dmem_array.sv | 32 +++
 rtl/data_mem_responder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and widths for the CPU data-memory responder.
package mem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_t;
  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with byte-enabled synchronous write and registered read; never reset.
module dmem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[idx];
      end
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder for the MEM stage: one outstanding request, fixed latency, range-checked.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 4096,
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  mem_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              oor_q, oor_d;
  logic              resp_load_q, resp_load_d;
  logic              resp_err_q, resp_err_d;
  logic              access;
  logic              req_oor;
  logic [WORD_W-1:0] arr_rdata;

  // Widen by one bit so DEPTH == 2**ADDR_W still compares correctly.
  assign req_oor = ({1'b0, req_addr} >= (ADDR_W+1)'(DEPTH));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    oor_d       = oor_q;
    resp_load_d = resp_load_q;
    resp_err_d  = resp_err_q;
    access      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          idx_d   = req_addr[IDX_W-1:0];
          wdata_d = req_wdata;
          be_d    = req_be;
          oor_d   = req_oor;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Out-of-range requests never touch the array but still take the full latency.
          access      = !oor_q;
          resp_load_d = !write_q && !oor_q;
          resp_err_d  = oor_q;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_load_d = 1'b0;
          resp_err_d  = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      oor_q       <= 1'b0;
      resp_load_q <= 1'b0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      oor_q       <= oor_d;
      resp_load_q <= resp_load_d;
      resp_err_q  <= resp_err_d;
    end
  end

  dmem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .en    (access),
    .we    (write_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .be    (be_q),
    .rdata (arr_rdata)
  );

  // The array's read register holds still through RESP, so gating it gives stable load data.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_load_q ? arr_rdata : '0;
  assign resp_err   = resp_err_q;
endmodule
